// File: rtl/compositor_pkg.sv
// Shared types and solid-screen colours for the sprite layer compositor.
package compositor_pkg;

  typedef enum logic [1:0] {
    MODE_PLAY  = 2'b00,
    MODE_START = 2'b01,
    MODE_OVER  = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_SHOW,
    ST_FADE_OUT,
    ST_SWAP,
    ST_FADE_IN
  } state_e;

  // 8-bit {R,G,B} references; the top MSB-aligns them to its channel width.
  localparam logic [23:0] COLOR_OVER  = 24'hAF_00_00;
  localparam logic [23:0] COLOR_CLEAR = 24'h00_AF_00;

endpackage

// File: rtl/fade_scaler.sv
// One colour channel scaled by a brightness level: (src * bright) >> FADE_LOG2.
module fade_scaler #(
  parameter int CW        = 8,
  parameter int FADE_LOG2 = 4
) (
  input  logic [CW-1:0]      src_i,
  input  logic [FADE_LOG2:0] bright_i,
  output logic [CW-1:0]      scaled_o
);

  localparam int PW = CW + FADE_LOG2 + 1;

  logic [PW-1:0] prod;
  logic          unused_prod;

  assign prod        = PW'(src_i) * PW'(bright_i);
  // bright never exceeds 2^FADE_LOG2, so the top product bit is always clear.
  assign scaled_o    = prod[FADE_LOG2 +: CW];
  assign unused_prod = ^{prod[PW-1], prod[FADE_LOG2-1:0]};

endmodule

// File: rtl/layer_compositor.sv
// Two-stage sprite compositor: priority/colour-key merge with damage flash,
// then screen-mode source select and frame-stepped fade between screens.
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int              NUM_LAYERS   = 8,
  parameter int              CW           = 8,
  parameter int              FADE_LOG2    = 4,
  parameter int              FLASH_FRAMES = 8,
  parameter logic [3*CW-1:0] KEY_COLOR    = '0
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       pix_valid_in,
  input  logic [NUM_LAYERS-1:0]      layer_hit,
  input  logic [NUM_LAYERS*3*CW-1:0] layer_rgb,
  input  logic [1:0]                 mode_req,
  input  logic                       frame_tick,
  input  logic                       flash_trig,
  output logic [CW-1:0]              VGA_R,
  output logic [CW-1:0]              VGA_G,
  output logic [CW-1:0]              VGA_B,
  output logic                       pix_valid_out,
  output logic                       fading
);

  localparam int PW         = 3 * CW;
  localparam int FADE_STEPS = 1 << FADE_LOG2;
  localparam int BW         = FADE_LOG2 + 1;
  localparam int FCW        = $clog2(FLASH_FRAMES + 1);

  localparam logic [BW-1:0]  BRIGHT_FULL = BW'(FADE_STEPS);
  localparam logic [FCW-1:0] FLASH_LOAD  = FCW'(FLASH_FRAMES);

  function automatic logic [CW-1:0] align8(input logic [7:0] v);
    logic [CW+7:0] t;
    t = {v, {CW{1'b0}}};
    return t[CW+7 -: CW];
  endfunction

  localparam logic [PW-1:0] SRC_OVER  = {align8(COLOR_OVER[23:16]),
                                         align8(COLOR_OVER[15:8]),
                                         align8(COLOR_OVER[7:0])};
  localparam logic [PW-1:0] SRC_CLEAR = {align8(COLOR_CLEAR[23:16]),
                                         align8(COLOR_CLEAR[15:8]),
                                         align8(COLOR_CLEAR[7:0])};

  state_e         state_q, state_d;
  mode_e          active_mode_q, active_mode_d;
  logic [BW-1:0]  bright_q, bright_d;
  logic [FCW-1:0] flash_q, flash_d;
  logic [PW-1:0]  s1_rgb_q, s1_rgb_d;
  logic           s1_valid_q;
  logic [PW-1:0]  vga_q, vga_d;
  logic           valid_q;
  logic           pick_l0;
  logic [PW-1:0]  src;
  mode_e          req;

  assign req = mode_e'(mode_req);

  // Retrigger reloads; a load in the same cycle as a frame tick wins.
  always_comb begin
    flash_d = flash_q;
    if (flash_trig) begin
      flash_d = FLASH_LOAD;
    end else if (frame_tick && flash_q != '0) begin
      flash_d = flash_q - FCW'(1);
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    s1_rgb_d = '0;
    pick_l0  = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_hit[i] && layer_rgb[i*PW +: PW] != KEY_COLOR) begin
        s1_rgb_d = layer_rgb[i*PW +: PW];
        pick_l0  = (i == 0);
      end
    end
    if (pick_l0 && flash_q != '0 && flash_q[0]) begin
      s1_rgb_d = '1;
    end
  end

  always_comb begin
    state_d       = state_q;
    active_mode_d = active_mode_q;
    bright_d      = bright_q;
    case (state_q)
      ST_SHOW: begin
        bright_d = BRIGHT_FULL;
        if (req != active_mode_q) state_d = ST_FADE_OUT;
      end
      ST_FADE_OUT: begin
        if (bright_q == '0) begin
          state_d = ST_SWAP;
        end else if (frame_tick) begin
          bright_d = bright_q - BW'(1);
        end
      end
      ST_SWAP: begin
        active_mode_d = req;
        state_d       = ST_FADE_IN;
      end
      ST_FADE_IN: begin
        // A new request reverses from the current level rather than restarting.
        if (req != active_mode_q) begin
          state_d = ST_FADE_OUT;
        end else if (bright_q == BRIGHT_FULL) begin
          state_d = ST_SHOW;
        end else if (frame_tick) begin
          bright_d = bright_q + BW'(1);
        end
      end
      default: state_d = ST_SHOW;
    endcase
  end

  always_comb begin
    src = s1_rgb_q;
    case (active_mode_q)
      MODE_PLAY:  src = s1_rgb_q;
      MODE_START: src = '1;
      MODE_OVER:  src = SRC_OVER;
      default:    src = SRC_CLEAR;
    endcase
  end

  for (genvar c = 0; c < 3; c++) begin : g_ch
    fade_scaler #(
      .CW       (CW),
      .FADE_LOG2(FADE_LOG2)
    ) u_scaler (
      .src_i   (src[c*CW +: CW]),
      .bright_i(bright_q),
      .scaled_o(vga_d[c*CW +: CW])
    );
  end

  // NOTE: the pixel data registers are reset as well, so the screen goes black
  // the instant Reset_n falls instead of showing stale colour.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= ST_SHOW;
      active_mode_q <= MODE_START;
      bright_q      <= BRIGHT_FULL;
      flash_q       <= '0;
      s1_rgb_q      <= '0;
      s1_valid_q    <= 1'b0;
      vga_q         <= '0;
      valid_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample pre-edge values,
      // independent of statement order.
      state_q       <= state_d;
      active_mode_q <= active_mode_d;
      bright_q      <= bright_d;
      flash_q       <= flash_d;
      s1_rgb_q      <= s1_rgb_d;
      s1_valid_q    <= pix_valid_in;
      vga_q         <= vga_d;
      valid_q       <= s1_valid_q;
    end
  end

  assign VGA_R         = vga_q[PW-1 -: CW];
  assign VGA_G         = vga_q[2*CW-1 -: CW];
  assign VGA_B         = vga_q[CW-1:0];
  assign pix_valid_out = valid_q;
  assign fading        = (state_q != ST_SHOW);

endmodule

// File: tb/tb_layer_compositor.sv
// Randomized scoreboard bench for layer_compositor: default build plus a
// 3-layer, 4-bit build, both checked against a behavioural model.
module tb_layer_compositor;

  typedef struct {
    int          due;
    logic [31:0] rgb;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Default-parameter DUT
  logic         pv_a, tick_a, trig_a;
  logic [7:0]   hit_a;
  logic [191:0] rgb_a;
  logic [1:0]   mreq_a;
  logic [7:0]   r_a, g_a, b_a;
  logic         pvo_a, fading_a;

  // Small DUT: 3 layers, 4-bit channels
  logic         pv_b, tick_b, trig_b;
  logic [2:0]   hit_b;
  logic [35:0]  rgb_b;
  logic [1:0]   mreq_b;
  logic [3:0]   r_b, g_b, b_b;
  logic         pvo_b, fading_b;

  layer_compositor u_dut_a (
    .Clk(clk), .Reset_n(rst_n), .pix_valid_in(pv_a), .layer_hit(hit_a),
    .layer_rgb(rgb_a), .mode_req(mreq_a), .frame_tick(tick_a), .flash_trig(trig_a),
    .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a), .pix_valid_out(pvo_a), .fading(fading_a)
  );

  layer_compositor #(.NUM_LAYERS(3), .CW(4)) u_dut_b (
    .Clk(clk), .Reset_n(rst_n), .pix_valid_in(pv_b), .layer_hit(hit_b),
    .layer_rgb(rgb_b), .mode_req(mreq_b), .frame_tick(tick_b), .flash_trig(trig_b),
    .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b), .pix_valid_out(pvo_b), .fading(fading_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model (screen behaviour in plain integers) ----
  localparam int P_SHOW = 0, P_OUT = 1, P_SWAP = 2, P_IN = 3;
  int m_mode, m_bright, m_phase, m_flash;

  task automatic model_reset();
    m_mode = 1; m_bright = 16; m_phase = P_SHOW; m_flash = 0;
  endtask

  task automatic model_step(input int req, input bit tick, input bit trig);
    if (trig) m_flash = 8;
    else if (tick && m_flash > 0) m_flash = m_flash - 1;
    case (m_phase)
      P_SHOW: if (req != m_mode) m_phase = P_OUT;
      P_OUT:  if (m_bright == 0) m_phase = P_SWAP;
              else if (tick) m_bright = m_bright - 1;
      P_SWAP: begin m_mode = req; m_phase = P_IN; end
      default: if (req != m_mode) m_phase = P_OUT;
               else if (m_bright == 16) m_phase = P_SHOW;
               else if (tick) m_bright = m_bright + 1;
    endcase
  endtask

  function automatic logic [23:0] ref_pick(input logic [7:0] hit, input logic [191:0] rgb,
                                           input int flash);
    logic [23:0] c;
    for (int i = 0; i < 8; i++) begin
      c = rgb[i*24 +: 24];
      if (hit[i] && c != 24'h0) begin
        if (i == 0 && flash % 2 == 1) return 24'hFFFFFF;
        return c;
      end
    end
    return 24'h0;
  endfunction

  function automatic logic [23:0] ref_out(input int mode, input int bright, input logic [23:0] s1);
    logic [23:0] src, res;
    int v;
    case (mode)
      0: src = s1;
      1: src = 24'hFFFFFF;
      2: src = 24'hAF0000;
      default: src = 24'h00AF00;
    endcase
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      v = int'(src[ch*8 +: 8]) * bright / 16;
      res[ch*8 +: 8] = 8'(v);
    end
    return res;
  endfunction

  function automatic logic [11:0] ref_pick_b(input logic [2:0] hit, input logic [35:0] rgb);
    for (int i = 0; i < 3; i++)
      if (hit[i] && rgb[i*12 +: 12] != 12'h0) return rgb[i*12 +: 12];
    return 12'h0;
  endfunction

  // ---------------- scoreboards and monitors --------------------------------
  exp_t sb_a[$];
  exp_t sb_b[$];
  logic exp_fading = 1'b0;
  bit   fading_chk_en = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      if (fading_chk_en) check("fading", 32'(fading_a), 32'(exp_fading));
      if (pvo_a) begin
        if (sb_a.size() == 0) check("a_valid_extra", 32'(pvo_a), 32'd0);
        else begin
          e = sb_a.pop_front();
          check("a_latency", 32'(cyc), 32'(e.due));
          check("a_pixel", {8'h0, r_a, g_a, b_a}, e.rgb);
        end
      end else if (sb_a.size() > 0 && sb_a[0].due <= cyc) begin
        check("a_valid_missing", 32'(pvo_a), 32'd1);
        sb_a.delete(0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      if (pvo_b) begin
        if (sb_b.size() == 0) check("b_valid_extra", 32'(pvo_b), 32'd0);
        else begin
          e = sb_b.pop_front();
          check("b_latency", 32'(cyc), 32'(e.due));
          check("b_pixel", {20'h0, r_b, g_b, b_b}, e.rgb);
        end
      end else if (sb_b.size() > 0 && sb_b[0].due <= cyc) begin
        check("b_valid_missing", 32'(pvo_b), 32'd1);
        sb_b.delete(0);
      end
    end
  end

  // ---------------- stimulus for the default DUT ----------------------------
  logic         cur_valid;
  logic [7:0]   cur_hit;
  logic [191:0] cur_rgb;
  int           cur_mode;
  bit           cur_tick, cur_trig;

  task automatic apply_a();
    pv_a = cur_valid; hit_a = cur_hit; rgb_a = cur_rgb;
    mreq_a = 2'(cur_mode); tick_a = cur_tick; trig_a = cur_trig;
  endtask

  task automatic step_a();
    logic [23:0] s1;
    @(posedge clk); #1;
    exp_fading = (m_phase != P_SHOW);
    apply_a();
    s1 = ref_pick(cur_hit, cur_rgb, m_flash);
    model_step(cur_mode, cur_tick, cur_trig);
    if (cur_valid) sb_a.push_back('{cyc + 2, {8'h0, ref_out(m_mode, m_bright, s1)}});
  endtask

  task automatic rand_pixel_a();
    cur_valid = ($urandom_range(0, 3) != 0);
    cur_hit   = 8'($urandom);
    for (int i = 0; i < 8; i++)
      cur_rgb[i*24 +: 24] = ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom);
  endtask

  task automatic run_random(input int n, input int tick_div, input int trig_div);
    for (int i = 0; i < n; i++) begin
      rand_pixel_a();
      cur_tick = (i % tick_div == 0);
      cur_trig = ($urandom_range(0, trig_div - 1) == 0);
      step_a();
    end
  endtask

  task automatic run_until_show(input int mode, input int tick_div);
    cur_mode = mode;
    for (int i = 0; i < 600; i++) begin
      rand_pixel_a();
      cur_tick = (i % tick_div == 0);
      cur_trig = ($urandom_range(0, 24) == 0);
      step_a();
      if (m_phase == P_SHOW && m_mode == mode) break;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    cur_valid = 0; cur_hit = '0; cur_rgb = '0; cur_mode = 1; cur_tick = 0; cur_trig = 0;
    apply_a();
    pv_b = 0; hit_b = '0; rgb_b = '0; mreq_b = 2'b01; tick_b = 0; trig_b = 0;
    rst_n = 1'b0;
    #3;
    check("reset_vga", {8'h0, r_a, g_a, b_a}, 32'h0);
    check("reset_valid", 32'(pvo_a), 32'd0);
    check("reset_fading", 32'(fading_a), 32'd0);
    #19 rst_n = 1'b1;
    fading_chk_en = 1'b1;

    // START -> PLAY fade, random pixels at every brightness
    run_until_show(0, 3);

    // Priority with a keyed layer falling through
    cur_valid = 1; cur_hit = 8'b0000_0110;
    for (int i = 0; i < 8; i++) cur_rgb[i*24 +: 24] = 24'($urandom);
    cur_rgb[24 +: 24] = 24'h000000;
    cur_rgb[48 +: 24] = 24'h123456;
    cur_tick = 0; cur_trig = 0;
    step_a();
    run_random(60, 4, 15);

    // Damage flash on layer 0; first let any running flash expire
    cur_trig = 0; cur_tick = 1; cur_valid = 0;
    repeat (10) step_a();
    cur_valid = 1; cur_hit = 8'hFF; cur_rgb[0 +: 24] = 24'h00FF00;
    cur_tick = 0; cur_trig = 1;
    step_a();
    cur_trig = 0;
    for (int i = 0; i < 30; i++) begin
      cur_tick = (i % 3 == 0);
      step_a();
    end
    cur_tick = 1; cur_trig = 1;
    step_a();
    cur_trig = 0;
    for (int i = 1; i < 9; i++) begin
      cur_tick = (i % 4 == 0);
      step_a();
    end

    // PLAY -> OVER full fade
    run_until_show(2, 2);
    run_random(6, 5, 40);

    // OVER -> PLAY, reversed to CLEAR during fade-in at level 5
    cur_mode = 0;
    for (int i = 0; i < 600; i++) begin
      rand_pixel_a();
      cur_tick = (i % 2 == 0); cur_trig = 0;
      step_a();
      if (m_phase == P_IN && m_bright == 5) break;
    end
    run_until_show(3, 2);
    cur_valid = 1; cur_tick = 0;
    repeat (4) step_a();

    // Reset in the middle of a fade-out at level 7
    cur_mode = 2;
    for (int i = 0; i < 600; i++) begin
      rand_pixel_a();
      cur_tick = (i % 2 == 0); cur_trig = 0;
      step_a();
      if (m_phase == P_OUT && m_bright == 7) break;
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midfade_rst_vga", {8'h0, r_a, g_a, b_a}, 32'h0);
    check("midfade_rst_valid", 32'(pvo_a), 32'd0);
    check("midfade_rst_fading", 32'(fading_a), 32'd0);
    fading_chk_en = 1'b0;
    sb_a.delete();
    model_reset();
    cur_mode = 1; cur_valid = 0; cur_tick = 0; cur_trig = 0;
    apply_a();
    repeat (3) @(posedge clk);
    #3;
    exp_fading = 1'b0;
    rst_n = 1'b1;
    fading_chk_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rand_pixel_a();
      cur_valid = 1; cur_tick = (i % 2 == 0); cur_trig = 0;
      step_a();
    end
    cur_valid = 0; cur_tick = 0;
    step_a();
    @(posedge clk); #1;
    fading_chk_en = 1'b0;

    // Small build: bring it to PLAY, then sweep every hit combination
    mreq_b = 2'b00; tick_b = 1;
    repeat (50) @(posedge clk);
    #1 tick_b = 0;
    check("b_fading_settled", 32'(fading_b), 32'd0);
    for (int h = 0; h < 8; h++) begin
      for (int r = 0; r < 6; r++) begin
        @(posedge clk); #1;
        hit_b = 3'(h);
        for (int l = 0; l < 3; l++)
          rgb_b[l*12 +: 12] = ($urandom_range(0, 2) == 0) ? 12'h0 : 12'($urandom);
        pv_b = 1;
        sb_b.push_back('{cyc + 2, {20'h0, ref_pick_b(hit_b, rgb_b)}});
      end
    end
    @(posedge clk); #1 pv_b = 0;

    repeat (4) @(posedge clk);
    #1;
    check("a_drain", 32'(sb_a.size()), 32'd0);
    check("b_drain", 32'(sb_b.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
